// File: rtl/pipes.sv
// Shared pipeline types and system-level constants for the front end.
package pipes;

   localparam int unsigned FQ_DEPTH = 4;

   typedef struct packed {
      logic       exception;
      logic [3:0] cause;
   } except_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        valid;
      except_t     except;
   } fetch_data_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Register-array storage for the fetch queue: one write port, one asynchronous read port.
module fetch_queue_mem #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode; strict FIFO with single-cycle flush.
module fetch_queue
   import pipes::*;
#(
   parameter int unsigned DEPTH = FQ_DEPTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   enq_valid,
   input  fetch_data_t            enq_data,
   output logic                   enq_ready,
   output logic                   deq_valid,
   output fetch_data_t            deq_data,
   input  logic                   deq_ready,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

   logic [AW-1:0]            wp_q, rp_q;
   logic [AW:0]              count_q;
   logic                     enq_fire, deq_fire;
   logic [$bits(fetch_data_t)-1:0] rdata;

   // Ready depends on registered state only, so a full queue refuses even when decode drains.
   assign enq_ready = (count_q != FullCount);
   assign deq_valid = (count_q != '0);
   assign count     = count_q;
   assign enq_fire  = enq_valid & enq_ready & ~flush;
   assign deq_fire  = deq_valid & deq_ready & ~flush;
   assign deq_data  = fetch_data_t'(rdata);

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
      end else begin
         if (enq_fire) begin
            wp_q <= wp_q + AW'(1);
         end
         if (deq_fire) begin
            rp_q <= rp_q + AW'(1);
         end
         case ({enq_fire, deq_fire})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   fetch_queue_mem #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fetch_data_t))
   ) u_mem (
      .clk   (clk),
      .we    (enq_fire),
      .waddr (wp_q),
      .wdata (enq_data),
      .raddr (rp_q),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic against a queue model.
module tb_fetch_queue;
   import pipes::*;

   localparam int unsigned DEPTH = FQ_DEPTH;

   logic                   clk = 1'b0;
   logic                   reset, flush, enq_valid, deq_ready;
   fetch_data_t            enq_data;
   logic                   enq_ready, deq_valid;
   fetch_data_t            deq_data;
   logic [$clog2(DEPTH):0] count;

   int          errors = 0;
   int          checks = 0;
   fetch_data_t model[$];
   bit          model_known = 1'b0;

   always #5 clk = ~clk;

   fetch_queue #(
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .enq_valid (enq_valid),
      .enq_data  (enq_data),
      .enq_ready (enq_ready),
      .deq_valid (deq_valid),
      .deq_data  (deq_data),
      .deq_ready (deq_ready),
      .count     (count)
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic fetch_data_t mk(input logic [31:0] pc);
      fetch_data_t d;
      d.pc     = pc;
      d.instr  = $urandom;
      d.valid  = 1'b1;
      d.except = '0;
      return d;
   endfunction

   // Compare outputs against the model, advance the model by one cycle, then cross the edge.
   task automatic cycle();
      if (model_known) begin
         check_eq("count", count, model.size());
         check_eq("enq_ready", enq_ready, model.size() != DEPTH);
         check_eq("deq_valid", deq_valid, model.size() != 0);
         if (model.size() != 0) check_eq("deq_data", deq_data, model[0]);
      end
      if (reset || flush) begin
         model.delete();
         if (reset) model_known = 1'b1;
      end else if (model_known) begin
         bit do_enq;
         bit do_deq;
         do_enq = enq_valid && (model.size() < DEPTH);
         do_deq = deq_ready && (model.size() > 0);
         if (do_deq) void'(model.pop_front());
         if (do_enq) model.push_back(enq_data);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input logic [31:0] base, input int n);
      deq_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
         enq_valid = 1'b1;
         enq_data  = mk(base + 32'(4 * i));
         cycle();
      end
      enq_valid = 1'b0;
   endtask

   task automatic drain();
      enq_valid = 1'b0;
      deq_ready = 1'b1;
      for (int i = 0; i < DEPTH + 2 && deq_valid; i++) cycle();
      check_eq("drain_empty", deq_valid, 1'b0);
      deq_ready = 1'b0;
   endtask

   initial begin
      fetch_data_t e;
      logic [31:0] last_pc;
      reset = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0; enq_data = '0;
      cycle();
      cycle();
      reset = 1'b0;

      // Idle after reset
      for (int i = 0; i < 5; i++) begin
         check_eq("idle_deq_valid", deq_valid, 1'b0);
         check_eq("idle_enq_ready", enq_ready, 1'b1);
         check_eq("idle_count", count, 0);
         cycle();
      end

      // Fill to full, 5th entry held off, then drain in order
      fill(32'h8000_0000, 4);
      check_eq("full_count", count, 4);
      check_eq("full_enq_ready", enq_ready, 1'b0);
      enq_valid = 1'b1;
      enq_data  = mk(32'h8000_0010);
      cycle();
      enq_valid = 1'b0;
      deq_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_eq("drain_valid", deq_valid, 1'b1);
         check_eq("drain_pc", deq_data.pc, 32'h8000_0000 + 32'(4 * i));
         cycle();
      end
      check_eq("drained_valid", deq_valid, 1'b0);
      deq_ready = 1'b0;

      // Steady stream from empty
      for (int i = 0; i < 20; i++) begin
         enq_valid = 1'b1;
         deq_ready = 1'b1;
         enq_data  = mk(32'h8000_1000 + 32'(4 * i));
         if (i == 0) begin
            check_eq("stream_first_empty", deq_valid, 1'b0);
         end else begin
            check_eq("stream_valid", deq_valid, 1'b1);
            check_eq("stream_count", count, 1);
            check_eq("stream_pc", deq_data.pc, 32'h8000_1000 + 32'(4 * (i - 1)));
         end
         cycle();
      end
      drain();

      // Flush with 3 entries while enqueuing
      fill(32'h8000_0020, 3);
      flush     = 1'b1;
      enq_valid = 1'b1;
      enq_data  = mk(32'h8000_0100);
      cycle();
      flush     = 1'b0;
      enq_valid = 1'b0;
      check_eq("flush_count", count, 0);
      check_eq("flush_deq_valid", deq_valid, 1'b0);
      fill(32'h8000_0200, 1);
      check_eq("post_flush_pc", deq_data.pc, 32'h8000_0200);
      drain();

      // Exception entry passes through untouched
      e.pc = 32'h8000_0002; e.instr = $urandom; e.valid = 1'b0;
      e.except.exception = 1'b1; e.except.cause = 4'h2;
      enq_valid = 1'b1;
      enq_data  = e;
      cycle();
      enq_valid = 1'b0;
      check_eq("exc_valid", deq_valid, 1'b1);
      check_eq("exc_data", deq_data, e);
      drain();

      // Full with simultaneous dequeue: enqueue refused, accepted next cycle
      fill(32'h8000_0300, 4);
      enq_valid = 1'b1;
      deq_ready = 1'b1;
      enq_data  = mk(32'h8000_0400);
      cycle();
      check_eq("full_simul_count", count, 3);
      deq_ready = 1'b0;
      cycle();
      check_eq("retry_count", count, 4);
      enq_valid = 1'b0;
      deq_ready = 1'b1;
      last_pc   = '0;
      for (int i = 0; i < DEPTH + 2 && deq_valid; i++) begin
         last_pc = deq_data.pc;
         cycle();
      end
      check_eq("retry_last_pc", last_pc, 32'h8000_0400);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         enq_valid = ($urandom_range(0, 99) < 60);
         deq_ready = ($urandom_range(0, 99) < 50);
         flush     = ($urandom_range(0, 99) < 4);
         reset     = ($urandom_range(0, 199) == 0);
         enq_data  = {$urandom, $urandom, 6'($urandom)};
         cycle();
      end
      reset = 1'b0; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
      cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
